// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART controller: buffers host writes and launches
// one byte at a time on tx_start, holding off the next launch until tx_done.
module uart_tx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    state_t            state;
    state_t            state_nxt;
    logic              wr_acc;
    logic              wr_drop;
    logic              pop;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;
    assign busy  = (state == S_WAIT);

    // flush swallows a concurrent write and leaves overflow untouched
    assign wr_acc  = wr_en && !full && !flush;
    assign wr_drop = wr_en && full && !flush;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !flush) begin
                    pop       = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({wr_acc, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            tx_start <= pop;
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted writes queue expected bytes, a
// monitor pops and compares on each tx_start, plus directed status checks.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              flush;
    logic              clr_ovf;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              busy;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q [$];
    int         n_cmp;
    int         n_err;
    int         n_launch;
    bit         auto_done;
    logic [7:0] last_launch;
    logic       prev_busy;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic write(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        step();
        wr_en = 1'b0;
    endtask

    task automatic send_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k;
        k = 0;
        while ((busy || count != 0) && k < limit) begin
            step();
            k++;
        end
        chk(name, {26'd0, busy, count}, 32'd0);
    endtask

    task automatic drain(input string name, input int limit);
        if (busy) send_done();
        auto_done = 1'b1;
        wait_idle(name, limit);
        auto_done = 1'b0;
        step();
    endtask

    task automatic monitor_loop();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
            end else begin
                if (tx_start) begin
                    chk("start_while_busy", {31'd0, prev_busy}, 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("launch_unexpected", {31'd0, tx_start}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("launch_byte", {24'd0, tx_data}, {24'd0, e});
                    end
                    last_launch = tx_data;
                    n_launch++;
                end else if (busy) begin
                    chk("tx_data_hold", {24'd0, tx_data}, {24'd0, last_launch});
                end
                prev_busy = busy;
            end
        end
    endtask

    task automatic responder_loop();
        int d;
        forever begin
            @(negedge clk);
            if (!rst && tx_start && auto_done) begin
                d = $urandom_range(130, 100);
                repeat (d) @(negedge clk);
                #1 tx_done = 1'b1;
                @(negedge clk);
                #1 tx_done = 1'b0;
            end
        end
    endtask

    initial begin
        int saved;
        int k;
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = '0;
        flush       = 1'b0;
        clr_ovf     = 1'b0;
        tx_done     = 1'b0;
        auto_done   = 1'b0;
        n_cmp       = 0;
        n_err       = 0;
        n_launch    = 0;
        last_launch = '0;
        prev_busy   = 1'b0;

        fork
            monitor_loop();
            responder_loop();
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // reset state
        repeat (3) step();
        rst = 1'b0;
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);

        // single byte latency
        write(8'hA5);
        chk("t1_count_after_write", {27'd0, count}, 32'd1);
        chk("t1_empty_after_write", {31'd0, empty}, 32'd0);
        chk("t1_no_early_start", {31'd0, tx_start}, 32'd0);
        step();
        chk("t1_start", {31'd0, tx_start}, 32'd1);
        chk("t1_tx_data", {24'd0, tx_data}, 32'hA5);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_count_after_pop", {27'd0, count}, 32'd0);
        step();
        chk("t1_start_one_cycle", {31'd0, tx_start}, 32'd0);
        repeat (3) step();
        chk("t1_busy_held", {31'd0, busy}, 32'd1);
        send_done();
        chk("t1_busy_after_done", {31'd0, busy}, 32'd0);

        // fill to full and overflow
        for (int i = 0; i < 16; i++) write(8'(i));
        chk("t2_count15", {27'd0, count}, 32'd15);
        chk("t2_not_full", {31'd0, full}, 32'd0);
        chk("t2_no_ovf_yet", {31'd0, overflow}, 32'd0);
        write(8'h10);
        chk("t2_count16", {27'd0, count}, 32'd16);
        chk("t2_full", {31'd0, full}, 32'd1);
        clr_ovf = 1'b1;
        write(8'h11);
        clr_ovf = 1'b0;
        chk("t2_count_after_drop", {27'd0, count}, 32'd16);
        chk("t2_overflow_set_wins", {31'd0, overflow}, 32'd1);
        saved = n_launch;
        drain("t2_drain", 3000);
        chk("t2_launches", n_launch - saved, 32'd16);

        // simultaneous write and pop at count 3
        write(8'h21); write(8'h22); write(8'h23); write(8'h24);
        chk("t3_count3", {27'd0, count}, 32'd3);
        send_done();
        chk("t3_idle", {31'd0, busy}, 32'd0);
        chk("t3_count3_idle", {27'd0, count}, 32'd3);
        write(8'h25);
        chk("t3_count_stays3", {27'd0, count}, 32'd3);
        chk("t3_start", {31'd0, tx_start}, 32'd1);
        chk("t3_oldest", {24'd0, tx_data}, 32'h22);
        chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
        drain("t3_drain", 1000);

        // 40 bytes across pointer wrap with slow UART
        auto_done = 1'b1;
        saved = n_launch;
        for (int i = 0; i < 40; i++) begin
            k = 0;
            while (exp_q.size() >= DEPTH && k < 5000) begin
                step();
                k++;
            end
            write(8'h80 + 8'(i));
        end
        wait_idle("t4_drain", 8000);
        auto_done = 1'b0;
        step();
        chk("t4_launches", n_launch - saved, 32'd40);
        chk("t4_no_overflow", {31'd0, overflow}, 32'd0);

        // flush while waiting with count 5
        for (int i = 0; i < 6; i++) write(8'h51 + 8'(i));
        chk("t5_count5", {27'd0, count}, 32'd5);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        exp_q.delete();
        step();
        flush = 1'b0;
        chk("t5_count0", {27'd0, count}, 32'd0);
        chk("t5_empty", {31'd0, empty}, 32'd1);
        chk("t5_busy_kept", {31'd0, busy}, 32'd1);
        chk("t5_tx_data_kept", {24'd0, tx_data}, 32'h51);
        saved = n_launch;
        send_done();
        repeat (5) step();
        chk("t5_no_new_start", n_launch - saved, 32'd0);
        chk("t5_idle", {31'd0, busy}, 32'd0);

        // reset mid-transfer
        for (int i = 0; i < 5; i++) write(8'h61 + 8'(i));
        chk("t6_count4", {27'd0, count}, 32'd4);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_count", {27'd0, count}, 32'd0);
        chk("t6_rst_empty", {31'd0, empty}, 32'd1);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("t6_rst_tx_start", {31'd0, tx_start}, 32'd0);
        step();
        step();
        rst = 1'b0;
        send_done();
        chk("t6_stale_done_ignored", {26'd0, busy, count}, 32'd0);
        write(8'h3C);
        step();
        chk("t6_start", {31'd0, tx_start}, 32'd1);
        chk("t6_tx_data", {24'd0, tx_data}, 32'h3C);
        send_done();
        step();
        chk("t6_idle", {31'd0, busy}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
